fft_mem_arbiter: RTL and testbench



---
 rtl/fft_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fft_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mem_arbiter.sv
// fft_mem_arbiter: shares one single-port RAM between the host loader and the FFT
// engine. The RAM holds two ping-pong buffers, and each requester sees half of it.
// A one-cycle drain state lets an in-flight read return before buffer ownership
// is exchanged.
//
// Optional build macro: FFT_MEM_ARB_CONFLICT_CNT_EN
//   Defined:   conflict_cnt_o counts, saturating, the cycles where both requesters assert req.
//   Undefined: the counter is removed and conflict_cnt_o is tied to zero.
//
// Handshake: a requester raises req with its we/addr/wdata fields and keeps them
// stable until it sees gnt high in the same cycle. That cycle is the transfer.
// Read data comes back with rvalid exactly one cycle after the read grant.
// gnt is never registered: it depends combinationally on req and on the state.
module fft_mem_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  pclk_i,
  input  logic                  preset_n_i,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-2:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  input  logic                  eng_req_i,
  input  logic                  eng_we_i,
  input  logic [ADDR_WIDTH-2:0] eng_addr_i,
  input  logic [DATA_WIDTH-1:0] eng_wdata_i,
  output logic                  eng_gnt_o,
  output logic                  eng_rvalid_o,
  output logic [DATA_WIDTH-1:0] eng_rdata_o,
  input  logic                  swap_req_i,
  output logic                  swap_ack_o,
  output logic                  buffer_active_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic [15:0]           conflict_cnt_o,
  output logic                  state_dbg_o
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic                  buffer_active_q;
  logic                  swap_ack_q;
  logic [7:0]            starve_q;
  logic                  rd_pend_q;
  logic                  rd_host_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;
  logic [DATA_WIDTH-1:0] eng_rdata_q;
  logic                  grant_ok;
  logic                  host_gnt;
  logic                  eng_gnt;

  // FSM state register
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next state: a swap request in IDLE starts a single drain cycle; requests are ignored in DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (swap_req_i) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Arbitration: the engine wins ties unless the host has waited STARVE_LIMIT cycles.
  // Grants are gated by reset so that nothing reaches the RAM while reset is held.
  assign grant_ok = preset_n_i && (state_q == IDLE);
  assign host_gnt = grant_ok && host_req_i && (!eng_req_i || (starve_q == STARVE_MAX));
  assign eng_gnt  = grant_ok && eng_req_i && !host_gnt;

  assign host_gnt_o      = host_gnt;
  assign eng_gnt_o       = eng_gnt;
  assign buffer_active_o = buffer_active_q;
  assign swap_ack_o      = swap_ack_q;
  assign state_dbg_o     = (state_q == DRAIN);

  // RAM port mux: the host always sees the buffer the engine does not own
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (host_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = host_we_i;
      ram_addr_o  = {~buffer_active_q, host_addr_i};
      ram_wdata_o = host_wdata_i;
    end else if (eng_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = eng_we_i;
      ram_addr_o  = {buffer_active_q, eng_addr_i};
      ram_wdata_o = eng_wdata_i;
    end
  end

  // Starvation counter: counts the IDLE cycles a host request loses, and clears on a host grant
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (host_gnt)
        starve_q <= '0;
      else if (host_req_i && (starve_q < STARVE_MAX))
        starve_q <= starve_q + 8'd1;
    end
  end

  // Buffer ownership flips as DRAIN ends, and the ack pulse is issued on that same edge
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      buffer_active_q <= 1'b0;
      swap_ack_q      <= 1'b0;
    end else begin
      swap_ack_q <= (state_q == DRAIN);
      if (state_q == DRAIN) buffer_active_q <= ~buffer_active_q;
    end
  end

  // Owner tag for the read in flight. Reset drops any pending return.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      rd_pend_q <= 1'b0;
      rd_host_q <= 1'b0;
    end else begin
      rd_pend_q <= ram_en_o && !ram_we_o;
      rd_host_q <= host_gnt;
    end
  end

  assign host_rvalid_o = rd_pend_q && rd_host_q;
  assign eng_rvalid_o  = rd_pend_q && !rd_host_q;
  assign host_rdata_o  = host_rvalid_o ? ram_rdata_i : host_rdata_q;
  assign eng_rdata_o   = eng_rvalid_o  ? ram_rdata_i : eng_rdata_q;

  // Each read data output keeps its last value until the next return to that requester
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      host_rdata_q <= '0;
      eng_rdata_q  <= '0;
    end else begin
      host_rdata_q <= host_rdata_o;
      eng_rdata_q  <= eng_rdata_o;
    end
  end

`ifdef FFT_MEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_q;

  // Saturating count of the cycles where both requesters assert req, in either state
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i)
      conflict_q <= '0;
    else if (host_req_i && eng_req_i && (conflict_q != 16'hFFFF))
      conflict_q <= conflict_q + 16'd1;
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fft_mem_arbiter.sv
// tb_fft_mem_arbiter: directed test-plan scenarios, then randomized traffic.
// Every check uses a transaction-level reference model: a shadow memory, a pending
// read, the buffer owner and the starvation and conflict tallies.
module tb_fft_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SL = 8;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          host_req, host_we, eng_req, eng_we, swap_req;
  logic [AW-2:0] host_addr, eng_addr;
  logic [DW-1:0] host_wdata, eng_wdata;
  logic          host_gnt, host_rvalid, eng_gnt, eng_rvalid;
  logic [DW-1:0] host_rdata, eng_rdata;
  logic          swap_ack, buffer_active, ram_en, ram_we, state_dbg;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   conflict_cnt;

  // The bench RAM has one cycle of read latency
  logic [DW-1:0] ram [2**AW];

  // Reference model state
  logic [DW-1:0] ref_mem [2**AW];
  logic          m_drain, m_ba, m_ack;
  int            m_starve, m_conf;
  logic          m_rd_pend, m_rd_host;
  logic [DW-1:0] m_rd_data, m_hrd, m_erd;
  logic          g_h, g_e;
  logic [DW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  fft_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .pclk_i(pclk), .preset_n_i(preset_n),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata),
    .eng_req_i(eng_req), .eng_we_i(eng_we), .eng_addr_i(eng_addr),
    .eng_wdata_i(eng_wdata), .eng_gnt_o(eng_gnt), .eng_rvalid_o(eng_rvalid),
    .eng_rdata_o(eng_rdata),
    .swap_req_i(swap_req), .swap_ack_o(swap_ack), .buffer_active_o(buffer_active),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .conflict_cnt_o(conflict_cnt), .state_dbg_o(state_dbg)
  );

  // Clock and bench RAM
  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_conflict();
`ifdef FFT_MEM_ARB_CONFLICT_CNT_EN
    return 16'(m_conf);
`else
    return 16'h0000;
`endif
  endfunction

  // Called right after a negedge with the inputs already driven. It checks one
  // cycle, advances the model past the posedge, and returns at the next negedge.
  task automatic step();
    logic          allowed, hw, ew;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    // Registered outputs: the read return and the swap and counter state
    check_eq("host_rvalid", host_rvalid, m_rd_pend && m_rd_host);
    check_eq("eng_rvalid", eng_rvalid, m_rd_pend && !m_rd_host);
    if (m_rd_pend) begin
      d = exp_q.pop_front();
      if (m_rd_host) m_hrd = d; else m_erd = d;
    end
    check_eq("host_rdata", host_rdata, m_hrd);
    check_eq("eng_rdata", eng_rdata, m_erd);
    check_eq("swap_ack", swap_ack, m_ack);
    check_eq("buffer_active", buffer_active, m_ba);
    check_eq("state_dbg", state_dbg, m_drain);
    check_eq("conflict_cnt", conflict_cnt, exp_conflict());

    // Arbitration and the RAM port
    allowed = !m_drain;
    hw      = allowed && host_req && (!eng_req || m_starve == SL);
    ew      = allowed && eng_req && !hw;
    check_eq("host_gnt", host_gnt, hw);
    check_eq("eng_gnt", eng_gnt, ew);
    check_eq("ram_en", ram_en, hw || ew);
    m_rd_pend = 1'b0;
    if (hw || ew) begin
      a = hw ? {~m_ba, host_addr} : {m_ba, eng_addr};
      check_eq("ram_addr", ram_addr, a);
      check_eq("ram_we", ram_we, hw ? host_we : eng_we);
      if (hw ? host_we : eng_we) begin
        d = hw ? host_wdata : eng_wdata;
        check_eq("ram_wdata", ram_wdata, d);
        ref_mem[a] = d;
      end else begin
        m_rd_pend = 1'b1;
        m_rd_host = hw;
        exp_q.push_back(ref_mem[a]);
      end
    end
    g_h = hw;
    g_e = ew;

    // Update the model to its state after the next clock edge
    if (host_req && eng_req && m_conf < 65535) m_conf++;
    if (allowed) begin
      if (hw) m_starve = 0;
      else if (host_req && m_starve < SL) m_starve++;
    end
    m_ack = m_drain;
    if (m_drain) begin
      m_drain = 1'b0;
      m_ba    = ~m_ba;
    end else begin
      m_drain = swap_req;
    end
    @(posedge pclk);
    @(negedge pclk);
  endtask

  // Reset driver: starts at a negedge, checks the reset values, and releases at a negedge
  task automatic apply_reset(input int cycles);
    preset_n = 1'b0;
    #1;
    check_eq("rst_host_gnt", host_gnt, 1'b0);
    check_eq("rst_eng_gnt", eng_gnt, 1'b0);
    check_eq("rst_ram_en", ram_en, 1'b0);
    check_eq("rst_host_rvalid", host_rvalid, 1'b0);
    check_eq("rst_eng_rvalid", eng_rvalid, 1'b0);
    check_eq("rst_host_rdata", host_rdata, '0);
    check_eq("rst_eng_rdata", eng_rdata, '0);
    check_eq("rst_swap_ack", swap_ack, 1'b0);
    check_eq("rst_buffer_active", buffer_active, 1'b0);
    check_eq("rst_conflict", conflict_cnt, 16'h0);
    check_eq("rst_state", state_dbg, 1'b0);
    repeat (cycles) @(negedge pclk);
    m_drain = 1'b0; m_ba = 1'b0; m_ack = 1'b0; m_starve = 0; m_conf = 0;
    m_rd_pend = 1'b0; m_hrd = '0; m_erd = '0;
    exp_q.delete();
    preset_n = 1'b1;
  endtask

  task automatic idle_inputs();
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    eng_req  = 1'b0; eng_we  = 1'b0; eng_addr  = '0; eng_wdata  = '0;
    swap_req = 1'b0;
  endtask

  // Random traffic: a pending request stays unchanged until it is granted
  task automatic rand_inputs();
    if (!host_req || g_h) begin
      host_req   = ($urandom_range(0, 2) != 0);
      host_we    = $urandom_range(0, 1);
      host_addr  = AW'($urandom_range(0, 1023));
      host_wdata = $urandom;
    end
    if (!eng_req || g_e) begin
      eng_req   = ($urandom_range(0, 3) != 0);
      eng_we    = $urandom_range(0, 1);
      eng_addr  = AW'($urandom_range(0, 1023));
      eng_wdata = $urandom;
    end
    if (swap_req) swap_req = ($urandom_range(0, 3) != 0) && !swap_ack;
    else          swap_req = ($urandom_range(0, 15) == 0);
  endtask

  int run_len;
  int hits;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram_rdata = '0;
    g_h = 1'b0; g_e = 1'b0;
    idle_inputs();
    preset_n = 1'b0;
    @(negedge pclk);
    apply_reset(2);

    // An engine read of 0x005 with buffer 0 active hits RAM address 0x005
    eng_req = 1'b1; eng_addr = 10'h005;
    #1 check_eq("eng_rd_addr", ram_addr, 11'h005);
    step();
    eng_req = 1'b0;
    check_eq("eng_rd_rvalid", eng_rvalid, 1'b1);
    check_eq("eng_rd_data", eng_rdata, ram[11'h005]);
    check_eq("eng_rd_host_quiet", host_rvalid, 1'b0);
    step();

    // The host writes 0x005 and lands in the other buffer, then reads it back
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h005; host_wdata = 32'hDEADBEEF;
    #1 check_eq("host_wr_addr", ram_addr, 11'h405);
    check_eq("host_wr_we", ram_we, 1'b1);
    step();
    check_eq("host_wr_no_rvalid", host_rvalid, 1'b0);
    host_we = 1'b0;
    step();
    host_req = 1'b0;
    check_eq("host_rd_data", host_rdata, 32'hDEADBEEF);
    step();

    // With both requesters held: 8 engine grants, then the host on the 9th cycle, repeating
    @(negedge pclk);
    apply_reset(1);
    host_req = 1'b1; host_we = 1'b1; eng_req = 1'b1; eng_we = 1'b1;
    for (int r = 0; r < 3; r++) begin
      run_len = 0;
      hits    = 0;
      while (hits == 0 && run_len < 20) begin
        eng_wdata = $urandom;
        step();
        if (g_h) hits = 1; else run_len++;
      end
      check_eq("starve_run", run_len, SL);
      host_wdata = $urandom;
    end
    check_eq("conflict_after_runs", conflict_cnt, exp_conflict());
    idle_inputs();
    step();

    // A read granted in the same cycle swap_req is raised returns during DRAIN, and the swap follows
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 10'h010; swap_req = 1'b1;
    step();
    check_eq("swap_rd_gnt", g_e, 1'b1);
    eng_req = 1'b0; swap_req = 1'b0;
    check_eq("drain_state", state_dbg, 1'b1);
    step();
    check_eq("swap_ba", buffer_active, 1'b1);
    check_eq("swap_ack_pulse", swap_ack, 1'b1);
    eng_req = 1'b1; eng_we = 1'b1; eng_wdata = $urandom;
    #1 check_eq("swap_new_map", ram_addr, 11'h410);
    step();
    idle_inputs();
    step();

    // A reset asserted during DRAIN gives no toggle and no ack
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 10'h3FF; swap_req = 1'b1;
    step();
    idle_inputs();
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rst_drain_no_ack", swap_ack, 1'b0);
    end

    // A reset asserted while a read is in flight drops its return
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h123;
    step();
    idle_inputs();
    apply_reset(1);
    step();

    // Randomized traffic with random swaps
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
